dmem_responder: RTL and testbench

- Data-memory responder for the pipelined LEGv8 CPU's MEM stage.
- Receives load/store requests (address, write data, transfer size) over a valid/ready handshake.
- Completes each request after a fixed, parameterised latency, then returns read data and an error flag over a valid/ready response channel.
- Lets the CPU exercise stall and forwarding logic against a multi-cycle memory instead of an ideal single-cycle one.

---
 rtl/dmem_responder.sv | 136 +++++++++++++
 tb/tb_dmem_responder.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Data-memory responder for a pipelined CPU MEM stage: one outstanding load/store,
// fixed LATENCY from accept to response, little-endian byte lanes in 64-bit words.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_size,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    logic          cap_write;
    logic [63:0]   cap_addr;
    logic [63:0]   cap_wdata;
    logic [3:0]    cap_size;

    logic [63:0]   mem [DEPTH_WORDS];

    logic          size_ok, align_ok, range_ok, legal, access, commit;
    logic [7:0]    size_mask, byte_en;
    logic [AW-1:0] widx;
    logic [2:0]    lane;
    logic [5:0]    shamt;
    logic [63:0]   bit_mask, rd_word, wr_shift, wr_word, ld_data;

    always_comb begin
        size_mask = 8'h00;
        case (cap_size)
            4'd1:    size_mask = 8'h01;
            4'd2:    size_mask = 8'h03;
            4'd4:    size_mask = 8'h0f;
            4'd8:    size_mask = 8'hff;
            default: size_mask = 8'h00;
        endcase
    end

    // size 8 wraps cap_size[2:0]-1 to 3'b111, which is exactly the 8-byte alignment mask
    assign size_ok  = |size_mask;
    assign align_ok = (cap_addr[2:0] & (cap_size[2:0] - 3'd1)) == 3'd0;
    assign range_ok = ~|cap_addr[63:3+AW];
    assign legal    = size_ok & align_ok & range_ok;

    assign widx    = cap_addr[3+AW-1:3];
    assign lane    = cap_addr[2:0];
    assign shamt   = {lane, 3'b000};
    assign byte_en = size_mask << lane;

    for (genvar g = 0; g < 8; g++) begin : g_lane
        assign bit_mask[8*g +: 8] = {8{byte_en[g]}};
    end

    assign rd_word  = mem[widx];
    assign wr_shift = cap_wdata << shamt;
    assign wr_word  = (rd_word & ~bit_mask) | (wr_shift & bit_mask);
    assign ld_data  = (rd_word & bit_mask) >> shamt;

    assign access = (state == BUSY) && (cnt == '0);
    assign commit = access && cap_write && legal;

    // Storage has no reset; commit is gated by state, which reset forces to IDLE.
    always_ff @(posedge clk) begin
        if (commit) mem[widx] <= wr_word;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_nxt = BUSY;
            end
            BUSY: if (cnt == '0) state_nxt = RESP;
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            cap_write  <= 1'b0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_size   <= '0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (req_valid) begin
                    cap_write <= req_write;
                    cap_addr  <= req_addr;
                    cap_wdata <= req_wdata;
                    cap_size  <= req_size;
                    cnt       <= CW'(LATENCY - 1);
                end
                BUSY: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        resp_rdata <= (legal && !cap_write) ? ld_data : 64'd0;
                        resp_err   <= ~legal;
                    end
                end
                RESP: if (resp_ready) begin
                    resp_rdata <= '0;
                    resp_err   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: latency, byte-lane merge, legality, backpressure, reset.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_write;
    logic [63:0] req_addr, req_wdata;
    logic [3:0]  req_size;
    logic        resp_valid, resp_ready;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(128), .LATENCY(2)) dut (
        .clk        (clk),
        .reset      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_size   (req_size),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
        else n_pass++;
    endtask

    // Issue one request, wait for its response, handshake it; lat = edges accept->resp_valid.
    task automatic xact(input logic w, input logic [63:0] a, input logic [63:0] d,
                        input logic [3:0] s, output logic [63:0] rd, output logic er,
                        output int lat);
        int to;
        to = 0;
        @(negedge clk);
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_size = s;
        while (!req_ready && to < 50) begin @(negedge clk); to++; end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!resp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rd, held;
        logic        er;
        int          lat, to;

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
        req_wdata = '0; req_size = '0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_rdata", resp_rdata, 0);
        chk("rst_err", resp_err, 0);
        rst_n = 1'b1;

        // 1: full-word store then load
        xact(1, 64'h10, 64'h0123456789ABCDEF, 4'd8, rd, er, lat);
        chk("t1_st_lat", lat, 2);
        chk("t1_st_err", er, 0);
        chk("t1_st_rdata", rd, 0);
        chk("t1_post_resp_valid", resp_valid, 0);
        xact(0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        chk("t1_ld_lat", lat, 2);
        chk("t1_ld_rdata", rd, 64'h0123456789ABCDEF);
        chk("t1_ld_err", er, 0);

        // 2: byte store ignores upper wdata bytes; partial loads
        xact(1, 64'h13, 64'hFFFFFFFFFFFFFFAA, 4'd1, rd, er, lat);
        chk("t2_st_err", er, 0);
        xact(0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        chk("t2_ld8", rd, 64'h01234567AAABCDEF);
        xact(0, 64'h12, 64'h0, 4'd2, rd, er, lat);
        chk("t2_ld2", rd, 64'h000000000000AAAB);
        chk("t2_ld2_err", er, 0);

        // 3: misaligned and bad size
        xact(0, 64'h12, 64'h0, 4'd4, rd, er, lat);
        chk("t3_misalign_err", er, 1);
        chk("t3_misalign_rdata", rd, 0);
        xact(1, 64'h10, 64'h5555555555555555, 4'd3, rd, er, lat);
        chk("t3_size3_err", er, 1);
        chk("t3_size3_lat", lat, 2);
        xact(0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        chk("t3_unchanged", rd, 64'h01234567AAABCDEF);

        // 4: range boundary
        xact(0, 64'h400, 64'h0, 4'd8, rd, er, lat);
        chk("t4_oob_err", er, 1);
        chk("t4_oob_rdata", rd, 0);
        xact(0, 64'h3F8, 64'h0, 4'd8, rd, er, lat);
        chk("t4_last_err", er, 0);

        // 5: response backpressure with a request waiting
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 64'h10; req_size = 4'd8;
        @(posedge clk); #1;
        req_addr = 64'h12; req_size = 4'd2;
        to = 0;
        while (!resp_valid && to < 50) begin @(posedge clk); #1; to++; end
        chk("t5_lat", to, 2);
        held = resp_rdata;
        chk("t5_rdata", held, 64'h01234567AAABCDEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("t5_hold_valid", resp_valid, 1);
            chk("t5_hold_rdata", resp_rdata, 64'h01234567AAABCDEF);
            chk("t5_hold_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        chk("t5_after_hs_valid", resp_valid, 0);
        chk("t5_after_hs_rdata", resp_rdata, 0);
        chk("t5_after_hs_ready", req_ready, 1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("t5_second_accepted", req_ready, 0);
        to = 0;
        while (!resp_valid && to < 50) begin @(posedge clk); #1; to++; end
        chk("t5_second_lat", to, 2);
        chk("t5_second_rdata", resp_rdata, 64'h000000000000AAAB);
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;

        // 6: reset during BUSY drops an uncommitted store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h10;
        req_wdata = 64'hFFFFFFFFFFFFFFFF; req_size = 4'd8;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        chk("t6_busy_ready", req_ready, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_async_req_ready", req_ready, 1);
        chk("t6_async_resp_valid", resp_valid, 0);
        chk("t6_async_rdata", resp_rdata, 0);
        chk("t6_async_err", resp_err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        xact(0, 64'h10, 64'h0, 4'd8, rd, er, lat);
        chk("t6_not_committed", rd, 64'h01234567AAABCDEF);
        chk("t6_ld_err", er, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
